alu_bist: RTL
=============

Name: alu_bist

Overview:
- Hardware self-test initiator for the CR16 ALU: drives operand pairs and ALUop codes into the ALU, samples aluResult and the C flag, and compares them against an internal golden model.
- Counts mismatches and reports pass/fail.
- Sits beside the ALU in the datapath; a mux in the top level gives it the ALU inputs while busy is high.

Parameters:
- WIDTH, 16, ALU data width.
- OPW, 8, sweep bits per operand; each operand sweeps 0..2^OPW-1 (OPW <= WIDTH).
- SETTLE, 1, cycles operands are held before sampling (>= 1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE or DONE.
- alu_result  in  WIDTH  ALU aluResult.
- alu_c  in  1  ALU carry flag.
- alu_a  out  WIDTH  operand A to ALU (aInput).
- alu_b  out  WIDTH  operand B to ALU (bInput).
- alu_op  out  3  ALUop code: 3'd0 = ADD, 3'd4 = SUB.
- busy  out  1  high while a run is in progress.
- done  out  1  sticky run-complete flag.
- pass  out  1  done && error_count == 0.
- error_count  out  16  mismatch count, saturating.
- fail_a, fail_b  out  WIDTH  first failing operands (optional feature).
- fail_op  out  3  first failing ALUop (optional feature).
- fail_result  out  WIDTH  first failing ALU result (optional feature).

Behaviour:
- Reset (async, rst_n low): state IDLE; alu_a, alu_b, alu_op, busy, done, pass, error_count and all fail_* are 0.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE/DONE + start:
  - Clear error_count, done and the fail_* capture.
  - Set op = ADD, a = 0, b = 0, settle counter = 0.
  - Next state DRIVE; busy goes high the cycle after start.
- DRIVE:
  - alu_a/alu_b/alu_op are registered and stable.
  - Stay until the settle counter reaches SETTLE-1, then go to CHECK.
- CHECK: sample alu_result and alu_c.
  - Golden ADD: {c, r} = a + b computed at WIDTH+1 bits. Mismatch if r != alu_result or c != alu_c.
  - Golden SUB: r = (a - b) mod 2^WIDTH. Only the result is checked; C is ignored.
  - On mismatch, error_count increments, saturating at 16'hFFFF.
- Advance after CHECK:
  - b increments.
  - When b wraps from 2^OPW-1, b = 0 and a increments.
  - When a also wraps: if op = ADD, set op = SUB and a = b = 0, then DRIVE; if op = SUB, go to DONE.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - A run is 2 * 2^(2*OPW) * (SETTLE+1) cycles, from the first DRIVE cycle to the last CHECK cycle inclusive.
- DONE:
  - busy = 0, done = 1, pass is valid.
  - Operand outputs hold their last values.
  - done stays high until the next accepted start or reset.
- start while busy: ignored, with no effect on counters.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No partial result is retained.
- Operands are zero-extended from OPW to WIDTH bits.

Optional Feature:
- Macro: ALU_BIST_FAILCAP_EN.
- Defined:
  - On the first mismatch of a run, latch fail_a, fail_b, fail_op and fail_result.
  - Later mismatches do not overwrite the capture.
  - The capture is cleared on an accepted start.
- Undefined: the fail_* ports exist but are tied to 0, and no capture registers are built.

Test Plan:
- OPW=2, SETTLE=1, ideal ALU model; pulse start → busy high for 64 cycles, then done=1, pass=1, error_count=0; alu_op is 0 for the first 32 cycles and 4 for the last 32.
- OPW=2, ALU result bit0 stuck at 0 → error_count=16 (8 odd ADD results + 8 odd SUB results), pass=0; with ALU_BIST_FAILCAP_EN: fail_a=0, fail_b=1, fail_op=0, fail_result=0.
- OPW=2, alu_c forced to 1 → error_count=16, all in the ADD phase (no true carry at OPW=2); SUB phase adds no errors.
- OPW=2, pulse start again 10 cycles into a run → ignored; run completes at the original cycle count with unchanged results.
- Drop rst_n low mid-run during the SUB phase → same cycle: busy=0, done=0, error_count=0, alu_op=0; a subsequent start runs cleanly to pass=1.
- OPW=2, SETTLE=3, ideal ALU → done after 128 cycles; alu_a/alu_b each held for 3 cycles before every CHECK.

Source files
------------

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test initiator for the CR16 ALU.
// Sweeps every operand pair 0..2^OPW-1 through ADD and then SUB, compares the
// ALU's result (and carry, for ADD) against a golden model and counts mismatches.
// Optional first-failure capture is built when ALU_BIST_FAILCAP_EN is defined;
// otherwise the fail_* ports are tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// DRIVE | operands on the ALU inputs, settle timer running
// CHECK | sample alu_result/alu_c, score, advance to the next vector
// DONE  | run complete, done/pass valid, operands hold last values

module alu_bist #(
    parameter int WIDTH  = 16,
    parameter int OPW    = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      error_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_op,
    output logic [WIDTH-1:0] fail_result
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bistState;

    bistState         state;
    logic [OPW-1:0]   aReg;
    logic [OPW-1:0]   bReg;
    logic [2:0]       opReg;
    logic [SW-1:0]    settleCnt;
    logic             busyReg;
    logic             doneReg;
    logic [15:0]      errCnt;

    logic [WIDTH-1:0] aExt;
    logic [WIDTH-1:0] bExt;
    logic [WIDTH:0]   addSum;
    logic [WIDTH-1:0] subDiff;
    logic             mismatch;
    logic             startOk;

    assign aExt    = WIDTH'(aReg);
    assign bExt    = WIDTH'(bReg);
    assign addSum  = {1'b0, aExt} + {1'b0, bExt};
    assign subDiff = aExt - bExt;
    assign startOk = start && ((state == IDLE) || (state == DONE));

    // Golden comparison; SUB deliberately ignores the carry flag.
    always_comb begin
        mismatch = 1'b0;
        if (opReg == OP_SUB) begin
            mismatch = (subDiff != alu_result);
        end else begin
            mismatch = (addSum[WIDTH-1:0] != alu_result) || (addSum[WIDTH] != alu_c);
        end
    end

    // Sequencer: operand sweep, settle timer, scoring and run status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            aReg      <= '0;
            bReg      <= '0;
            opReg     <= OP_ADD;
            settleCnt <= '0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            errCnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DRIVE;
                        aReg      <= '0;
                        bReg      <= '0;
                        opReg     <= OP_ADD;
                        settleCnt <= SETTLE_LOAD;
                        busyReg   <= 1'b1;
                        doneReg   <= 1'b0;
                        errCnt    <= '0;
                    end
                end
                DRIVE: begin
                    if (settleCnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settleCnt <= settleCnt - SW'(1);
                    end
                end
                CHECK: begin
                    if (mismatch && (errCnt != 16'hFFFF)) begin
                        errCnt <= errCnt + 16'd1;
                    end
                    settleCnt <= SETTLE_LOAD;
                    if (!(&bReg)) begin
                        bReg  <= bReg + OPW'(1);
                        state <= DRIVE;
                    end else if (!(&aReg)) begin
                        bReg  <= '0;
                        aReg  <= aReg + OPW'(1);
                        state <= DRIVE;
                    end else if (opReg == OP_ADD) begin
                        aReg  <= '0;
                        bReg  <= '0;
                        opReg <= OP_SUB;
                        state <= DRIVE;
                    end else begin
                        // Last SUB vector: operands stay on the bus in DONE.
                        state   <= DONE;
                        busyReg <= 1'b0;
                        doneReg <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_BIST_FAILCAP_EN
    logic [WIDTH-1:0] failAReg;
    logic [WIDTH-1:0] failBReg;
    logic [2:0]       failOpReg;
    logic [WIDTH-1:0] failResReg;

    // First mismatch of a run is the one seen while the error count is still zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            failAReg   <= '0;
            failBReg   <= '0;
            failOpReg  <= '0;
            failResReg <= '0;
        end else if (startOk) begin
            failAReg   <= '0;
            failBReg   <= '0;
            failOpReg  <= '0;
            failResReg <= '0;
        end else if ((state == CHECK) && mismatch && (errCnt == 16'd0)) begin
            failAReg   <= aExt;
            failBReg   <= bExt;
            failOpReg  <= opReg;
            failResReg <= alu_result;
        end
    end

    assign fail_a      = failAReg;
    assign fail_b      = failBReg;
    assign fail_op     = failOpReg;
    assign fail_result = failResReg;
`else
    logic unusedStartOk;
    assign unusedStartOk = startOk;
    assign fail_a      = '0;
    assign fail_b      = '0;
    assign fail_op     = '0;
    assign fail_result = '0;
`endif

    assign alu_a       = aExt;
    assign alu_b       = bExt;
    assign alu_op      = opReg;
    assign busy        = busyReg;
    assign done        = doneReg;
    assign error_count = errCnt;
    assign pass        = doneReg && (errCnt == 16'd0);

endmodule
